// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Serial line input plus received-byte handshake bundle for
//             uart_rx. The receiver owns the master view. The consumer owns
//             the slave view and also drives the line in a closed loop.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rxd;        // serial line, idles high
  logic       rd;         // one-cycle read/acknowledge strobe
  logic [7:0] data;       // received byte / FIFO head
  logic       valid;      // data holds an unread byte
  logic       frame_err;  // sticky: stop bit sampled low
  logic       overrun;    // sticky: a received byte was dropped
  logic       busy;       // a frame is in progress

  modport master (
    input  rxd,
    input  rd,
    output data,
    output valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rxd,
    output rd,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 LSB-first UART receiver with 16x oversampling. It has a
//             2-flop input synchronizer, start glitch rejection, and sticky
//             framing-error and overrun flags.
//  Config   : define UART_RX_FIFO_EN to replace the single holding register
//             with a 2^FIFO_AW-entry receive FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int DIVISOR = 27,  // system clocks per oversample tick
  parameter int FIFO_AW = 2    // FIFO address width (FIFO build only)
) (
  input wire        clk,
  input wire        rst,
  uart_rx_if.master bus
);

  localparam int              TW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  logic          sync1_q;
  logic          rx_s_q;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic          tick;

  state_e        state_q;
  logic [3:0]    scnt_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    shreg_q;
  logic          busy_q;

  logic          stop_sample;
  logic          deliver;
  logic          ferr_set;
  logic          ovr_set;

  logic          frame_err_q;
  logic          overrun_q;

  // Two-flop synchronizer. It resets to the idle (high) line level so reset
  // release cannot look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rxd;
      rx_s_q  <= sync1_q;
    end
  end

  // Next value of the free-running oversample divider, and the tick pulse.
  always_comb begin
    tick   = (tcnt_q == TMAX);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end

  // Oversample divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // Receive FSM. Every counter advances only on tick. busy is registered so
  // it changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            scnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            scnt_q <= '0;
            if (rx_s_q) begin
              // The line went high again before mid-bit, so this was a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              bcnt_q  <= '0;
            end
          end else begin
            scnt_q <= scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          scnt_q <= scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_q <= S_STOP;
              scnt_q  <= '0;
            end
          end
        end
        S_STOP: begin
          scnt_q <= scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stop-bit sample decode. A good stop delivers the byte. A bad stop
  // discards the byte and flags a framing error.
  always_comb begin
    stop_sample = (state_q == S_STOP) && tick && (scnt_q == 4'd15);
    deliver     = stop_sample && rx_s_q;
    ferr_set    = stop_sample && !rx_s_q;
  end

`ifdef UART_RX_FIFO_EN

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               full;
  logic               pop;
  logic               push;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // byte that arrives together with rd.
  always_comb begin
    full    = (count_q == DEPTH_CT);
    pop     = bus.rd && (count_q != '0);
    push    = deliver && (!full || pop);
    ovr_set = deliver && full && !pop;
  end

  // FIFO storage, pointers and occupancy. Both pointers wrap modulo depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= shreg_q;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.data  = mem_q[rptr_q];
  assign bus.valid = (count_q != '0);

`else

  logic [7:0]       data_q;
  logic             valid_q;
  logic [FIFO_AW:0] unused_fifo_aw;

  assign unused_fifo_aw = '0;

  // A new byte is dropped only when the holding register is full and not
  // being read in the same cycle.
  always_comb begin
    ovr_set = deliver && valid_q && !bus.rd;
  end

  // Single holding register. A read in the same cycle as a delivery makes
  // room for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (deliver && (!valid_q || bus.rd)) begin
      data_q  <= shreg_q;
      valid_q <= 1'b1;
    end else if (bus.rd) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;

`endif

  // Sticky status flags. rd clears them, but a set event in the same cycle
  // takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err_q <= 1'b1;
      end else if (bus.rd) begin
        frame_err_q <= 1'b0;
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (bus.rd) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. It uses a vector table,
//             hand-built timing sequences, and random frames checked against
//             a byte-queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int DIV    = 4;
  localparam int FAW    = 2;
  localparam int BITCLK = 16 * DIV;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 1 << FAW;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus ();

  uart_rx #(.DIVISOR(DIV), .FIFO_AW(FAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pre_rd;
    logic [7:0] b;
    logic       stop;
    logic       ev;
    logic [7:0] ed;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t vt [7];

  logic [7:0] q [$];
  logic       mfe;
  logic       mov;
  logic [7:0] rb;
  logic       rstop;
  int         nrd;
  int         wn;
  bit         wseen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    bus.rd = 1'b1;
    wait_clk(1);
    bus.rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.rxd = 1'b0;
    wait_clk(BITCLK);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      wait_clk(BITCLK);
    end
    bus.rxd = stop;
    wait_clk(BITCLK);
    bus.rxd = 1'b1;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [7:0] ed,
                           input logic ef, input logic eo);
    chk({tag, " valid"}, 32'(bus.valid), 32'(ev));
    if (ev) chk({tag, " data"}, 32'(bus.data), 32'(ed));
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'(ef));
    chk({tag, " overrun"}, 32'(bus.overrun), 32'(eo));
    chk({tag, " busy"}, 32'(bus.busy), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < CAP + 2; i++) begin
      if (bus.valid) pulse_rd();
    end
    pulse_rd();
    wait_clk(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    // vector table: {pre_rd, byte, stop, exp valid, exp data, exp ferr, exp ovr}
    vt[0] = '{1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
`ifdef UART_RX_FIFO_EN
    vt[3] = '{1'b0, 8'h20, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h7E, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0};
    vt[6] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
`else
    vt[3] = '{1'b0, 8'h20, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8'h7E, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0};
    vt[6] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
`endif

    // reset values
    rst     = 1'b1;
    bus.rxd = 1'b1;
    bus.rd  = 1'b0;
    wait_clk(3);
    chk("rst data", 32'(bus.data), 0);
    chk_state("in rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    wait_clk(2);
    chk_state("after rst", 1'b0, 8'h00, 1'b0, 1'b0);

    // short low pulse: start detected, then rejected at mid-bit
    bus.rxd = 1'b0;
    wait_clk(3 * DIV);
    bus.rxd = 1'b1;
    chk("glitch busy rise", 32'(bus.busy), 1);
    wait_clk(12 * DIV);
    chk_state("glitch", 1'b0, 8'h00, 1'b0, 1'b0);

    // table-driven frames
    foreach (vt[i]) begin
      if (vt[i].pre_rd) pulse_rd();
      wait_clk(DIV);
      send_frame(vt[i].b, vt[i].stop);
      wait_clk(16 * DIV);
      chk_state($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ef, vt[i].eo);
    end
    drain();
    chk("drained valid", 32'(bus.valid), 0);

    // rd on the exact stop-sample cycle of a second byte
    send_frame(8'h10, 1'b1);
    wait_clk(4 * DIV);
    chk_state("first of pair", 1'b1, 8'h10, 1'b0, 1'b0);
    fork
      send_frame(8'h20, 1'b1);
      begin
        wn    = 0;
        wseen = 1'b0;
        while (!wseen && wn < 4 * BITCLK) begin
          @(negedge clk);
          wn++;
          if (bus.busy) wseen = 1'b1;
        end
        chk("pair start seen", 32'(wseen), 1);
        if (wseen) begin
          repeat (152 * DIV - 1) @(posedge clk);
          #1;
          bus.rd = 1'b1;
          chk("busy before stop sample", 32'(bus.busy), 1);
          @(posedge clk);
          #1;
          bus.rd = 1'b0;
          chk("busy at stop sample", 32'(bus.busy), 0);
        end
      end
    join
    wait_clk(2);
    chk_state("rd with delivery", 1'b1, 8'h20, 1'b0, 1'b0);

`ifdef UART_RX_FIFO_EN
    // fill past capacity, then read back in order
    drain();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    wait_clk(2 * DIV);
    chk_state("fifo full", 1'b1, 8'h01, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fifo pop%0d data", k), 32'(bus.data), 32'(k));
      chk($sformatf("fifo pop%0d valid", k), 32'(bus.valid), 1);
      pulse_rd();
    end
    chk("fifo empty valid", 32'(bus.valid), 0);
`endif

    // reset in the middle of the data bits of 8'hA5
    bus.rxd = 1'b0;
    wait_clk(BITCLK);
    rb = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      bus.rxd = rb[i];
      wait_clk(BITCLK);
    end
    chk("busy mid frame", 32'(bus.busy), 1);
    bus.rxd = 1'b1;
    rst     = 1'b1;
    wait_clk(2);
    chk("mid rst data", 32'(bus.data), 0);
    chk_state("mid rst", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    wait_clk(BITCLK);
    chk_state("post rst idle", 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1);
    wait_clk(4 * DIV);
    chk_state("post rst frame", 1'b1, 8'h3C, 1'b0, 1'b0);

    // random frames against a byte-queue model
    drain();
    q.delete();
    mfe = 1'b0;
    mov = 1'b0;
    for (int f = 0; f < 30; f++) begin
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        pulse_rd();
        if (q.size() > 0) void'(q.pop_front());
        mfe = 1'b0;
        mov = 1'b0;
        wait_clk(1);
      end
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(rb, rstop);
      if (rstop) begin
        if (q.size() < CAP) q.push_back(rb);
        else mov = 1'b1;
        wait_clk($urandom_range(0, DIV));
      end else begin
        mfe = 1'b1;
        wait_clk(16 * DIV);
      end
      chk_state($sformatf("rand%0d", f), (q.size() > 0), (q.size() > 0) ? q[0] : 8'h00,
                mfe, mov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
